// File: rtl/fir_accumulator.sv
// Accumulates NUM_PAIRS partial sums per output sample with a valid/ready handshake.
// Define FIR_ACC_SAT_EN to clamp overflowing sums and raise a sticky sat_flag.
module fir_accumulator #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int NUM_PAIRS   = 4,
    parameter int OUT_WIDTH   = 18,
    localparam int IN_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat_flag
);

    localparam int PAIR_BITS = $clog2(NUM_PAIRS);
    localparam int ACC_WIDTH = IN_WIDTH + ((PAIR_BITS < 1) ? 1 : PAIR_BITS);
    localparam int CNT_WIDTH = $clog2(NUM_PAIRS) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_PAIRS - 1);
    localparam bit SINGLE = (NUM_PAIRS == 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ACC_WIDTH-1:0]   in_ext;
    logic [ACC_WIDTH-1:0]   next_sum;
    logic [OUT_WIDTH-1:0]   conv_data;
    logic                   accept;
    logic                   finish;

    // In HOLD a new input is only taken when the pending sample leaves.
    assign in_ready = (state == HOLD) ? out_ready : 1'b1;
    assign accept   = in_valid && in_ready;

    // Frame completes on the last pair; single-pair frames complete every accept.
    assign finish = SINGLE || ((state == ACCUM) && (cnt == LAST_CNT));

    // Running sum; outside ACCUM a new frame starts from the incoming value.
    always_comb begin
        in_ext   = ACC_WIDTH'(in_data);
        next_sum = in_ext;
        if (state == ACCUM) begin
            next_sum = acc + in_ext;
        end
    end

`ifdef FIR_ACC_SAT_EN
    logic conv_ovf;

    // Clamp the final sum to the output range and flag the overflow.
    if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
        always_comb begin
            conv_ovf  = |next_sum[ACC_WIDTH-1:OUT_WIDTH];
            conv_data = conv_ovf ? '1 : OUT_WIDTH'(next_sum);
        end
    end else begin : g_ext
        always_comb begin
            conv_ovf  = 1'b0;
            conv_data = OUT_WIDTH'(next_sum);
        end
    end

    // Sticky saturation indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (accept && finish && conv_ovf) begin
            sat_flag <= 1'b1;
        end
    end
`else
    // Final sum wraps (or zero-extends) into the output width.
    always_comb begin
        conv_data = OUT_WIDTH'(next_sum);
    end

    assign sat_flag = 1'b0;
`endif

    // Frame FSM: collect pairs, then hold the result until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept && finish) begin
            out_data  <= conv_data;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= HOLD;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= in_ext;
                        cnt   <= CNT_WIDTH'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= next_sum;
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            acc   <= in_ext;
                            cnt   <= CNT_WIDTH'(1);
                            state <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
